// File: rtl/reg_status_file_pkg.sv
// Shared defaults and zero constants for the register/status file slice.
package reg_status_file_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREG_DEFAULT  = 32;
    localparam int unsigned ROB_W_DEFAULT = 4;

    // Zero constants; size-cast at the point of use to the local widths.
    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned DATA_ZERO = 0;
    localparam int unsigned TAG_ZERO  = 0;

endpackage

// File: rtl/rsf_read_port.sv
// One operand read port: commit bypass for the value, then
// flush > rename > commit-clear > table priority for busy/tag.
module rsf_read_port
    import reg_status_file_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned REG_W = 5,
    parameter int unsigned ROB_W = ROB_W_DEFAULT,
    parameter int unsigned NCP   = 1
) (
    input  logic [REG_W-1:0]      rs_in,
    input  logic [XLEN-1:0]       tbl_val_in,
    input  logic                  tbl_busy_in,
    input  logic [ROB_W-1:0]      tbl_tag_in,
    input  logic                  flush_in,
    input  logic                  rn_en_in,
    input  logic [REG_W-1:0]      rn_rd_in,
    input  logic [ROB_W-1:0]      rn_tag_in,
    input  logic [NCP-1:0]        cm_en_in,
    input  logic [NCP*REG_W-1:0]  cm_rd_in,
    input  logic [NCP*XLEN-1:0]   cm_val_in,
    input  logic [NCP*ROB_W-1:0]  cm_tag_in,
    output logic [XLEN-1:0]       v_out,
    output logic [ROB_W-1:0]      q_out,
    output logic                  q_busy_out
);

    logic rs_live;
    logic cm_clr;

    // Resolve operand value and rename status for this port.
    always_comb begin
        rs_live    = (rs_in != REG_W'(REG_ZERO));
        v_out      = tbl_val_in;
        cm_clr     = 1'b0;
        q_busy_out = 1'b0;
        q_out      = ROB_W'(TAG_ZERO);

        // Ascending scan: the youngest matching commit lands last.
        for (int unsigned k = 0; k < NCP; k++) begin
            if (rs_live && cm_en_in[k] && (cm_rd_in[k*REG_W +: REG_W] == rs_in)) begin
                v_out = cm_val_in[k*XLEN +: XLEN];
                if (cm_tag_in[k*ROB_W +: ROB_W] == tbl_tag_in) begin
                    cm_clr = 1'b1;
                end
            end
        end

        if (!rs_live) begin
            v_out = XLEN'(DATA_ZERO);
        end

        if (flush_in) begin
            q_busy_out = 1'b0;
        end else if (rs_live && rn_en_in && (rn_rd_in == rs_in)) begin
            q_busy_out = 1'b1;
            q_out      = rn_tag_in;
        end else if (cm_clr) begin
            q_busy_out = 1'b0;
        end else if (rs_live && tbl_busy_in) begin
            q_busy_out = 1'b1;
            q_out      = tbl_tag_in;
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register busy bit and ROB tag.
// Holds the arrays, merges commits, applies rename/flush, and fans out
// NRP combinational read ports.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREG  = NREG_DEFAULT,
    parameter int unsigned ROB_W = ROB_W_DEFAULT,
    parameter int unsigned NRP   = 2,
    parameter int unsigned NCP   = 1,
    localparam int unsigned REG_W = $clog2(NREG)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  rn_en_in,
    input  logic [REG_W-1:0]      rn_rd_in,
    input  logic [ROB_W-1:0]      rn_tag_in,
    input  logic [NRP*REG_W-1:0]  rs_in,
    output logic [NRP*XLEN-1:0]   v_out,
    output logic [NRP*ROB_W-1:0]  q_out,
    output logic [NRP-1:0]        q_busy_out,
    input  logic [NCP-1:0]        cm_en_in,
    input  logic [NCP*REG_W-1:0]  cm_rd_in,
    input  logic [NCP*XLEN-1:0]   cm_val_in,
    input  logic [NCP*ROB_W-1:0]  cm_tag_in,
    input  logic                  flush_in
);

    logic [XLEN-1:0]  val_q  [NREG];
    logic             busy_q [NREG];
    logic [ROB_W-1:0] tag_q  [NREG];
    logic [NREG-1:0]  clr;
    logic             rn_live;

    // Per-register busy-clear request from any commit carrying the live tag.
    always_comb begin
        clr     = '0;
        rn_live = rn_en_in && (rn_rd_in != REG_W'(REG_ZERO));
        for (int unsigned r = 0; r < NREG; r++) begin
            for (int unsigned k = 0; k < NCP; k++) begin
                if (cm_en_in[k] && (cm_rd_in[k*REG_W +: REG_W] == REG_W'(r)) &&
                    (cm_tag_in[k*ROB_W +: ROB_W] == tag_q[r])) begin
                    clr[r] = 1'b1;
                end
            end
        end
    end

    // Array update: commits write values, then flush/rename/clear on status.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                val_q[r]  <= '0;
                busy_q[r] <= 1'b0;
                tag_q[r]  <= '0;
            end
        end else if (rdy_in) begin
            // Ascending port order so the youngest colliding commit wins.
            for (int unsigned k = 0; k < NCP; k++) begin
                if (cm_en_in[k] && (cm_rd_in[k*REG_W +: REG_W] != REG_W'(REG_ZERO))) begin
                    val_q[cm_rd_in[k*REG_W +: REG_W]] <= cm_val_in[k*XLEN +: XLEN];
                end
            end
            for (int unsigned r = 0; r < NREG; r++) begin
                if (flush_in) begin
                    busy_q[r] <= 1'b0;
                    tag_q[r]  <= '0;
                end else if (rn_live && (rn_rd_in == REG_W'(r))) begin
                    busy_q[r] <= 1'b1;
                    tag_q[r]  <= rn_tag_in;
                end else if (clr[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rp
        logic [REG_W-1:0] rs_w;
        assign rs_w = rs_in[p*REG_W +: REG_W];

        rsf_read_port #(
            .XLEN  (XLEN),
            .REG_W (REG_W),
            .ROB_W (ROB_W),
            .NCP   (NCP)
        ) u_rp (
            .rs_in       (rs_w),
            .tbl_val_in  (val_q[rs_w]),
            .tbl_busy_in (busy_q[rs_w]),
            .tbl_tag_in  (tag_q[rs_w]),
            .flush_in    (flush_in),
            .rn_en_in    (rn_en_in),
            .rn_rd_in    (rn_rd_in),
            .rn_tag_in   (rn_tag_in),
            .cm_en_in    (cm_en_in),
            .cm_rd_in    (cm_rd_in),
            .cm_val_in   (cm_val_in),
            .cm_tag_in   (cm_tag_in),
            .v_out       (v_out[p*XLEN +: XLEN]),
            .q_out       (q_out[p*ROB_W +: ROB_W]),
            .q_busy_out  (q_busy_out[p])
        );
    end

endmodule

// File: doc/reg_status_file.md
# reg_status_file

Parametrised architectural register file with per-register rename status: value array plus busy bit and ROB tag per register. Successor to the single-commit, two-read-port register block. Sits between dispatcher (rename writes, operand reads) and reorder buffer (in-order commit), and is cleared by the CDB rollback. Adds a configurable number of read and commit ports, an explicit busy bit (no sentinel tag), and fully defined same-cycle bypass and priority rules.

## Interface
- `XLEN`, default 32: data width.
- `NREG`, default 32: architectural registers; `REG_W = $clog2(NREG)`.
- `ROB_W`, default 4: ROB tag width.
- `NRP`, default 2: read ports.
- `NCP`, default 1: commit ports; a higher index is a younger instruction.
- `clk_in`  in  1  single clock, rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global stall; when 0, no state update.
- `rn_en_in`  in  1  rename valid from dispatcher.
- `rn_rd_in`  in  REG_W  renamed destination.
- `rn_tag_in`  in  ROB_W  ROB tag of the renaming instruction.
- `rs_in`  in  NRP*REG_W  source register per read port.
- `v_out`  out  NRP*XLEN  operand value per port.
- `q_out`  out  NRP*ROB_W  producer tag per port; 0 when not busy.
- `q_busy_out`  out  NRP  1 = operand pending on `q_out`.
- `cm_en_in`  in  NCP  commit valid per port.
- `cm_rd_in`  in  NCP*REG_W  commit destination.
- `cm_val_in`  in  NCP*XLEN  commit value.
- `cm_tag_in`  in  NCP*ROB_W  ROB tag of the committing entry.
- `flush_in`  in  1  rollback from CDB.

## Operation
- State: `val[NREG]`, `busy[NREG]`, `tag[NREG]`. Register x0: writes are dropped, renames are ignored, reads return value 0 and not busy.
- Commit port k with `cm_en_in[k]` and rd≠0 writes `val[rd]`. When ports collide on the same rd, the highest k wins the value.
- Busy clear: `busy[rd]` goes to 0 when any enabled commit port has a matching rd and `cm_tag_in` equals `tag[rd]`, and no same-cycle rename targets that rd. A commit with a stale tag writes the value but leaves busy and tag untouched.
- Rename (`rn_en_in`, rd≠0, no flush): `busy[rd]` <= 1 and `tag[rd]` <= `rn_tag_in`. A rename overrides any clear on the same rd.
- Flush: all `busy` <= 0 and all `tag` <= 0. A same-cycle rename is ignored. Same-cycle commits still write values.
- Read port p is combinational, evaluated in this priority order:
  - V: the youngest enabled commit whose rd matches, else `val[rs]`.
  - If `flush_in`: busy = 0, q = 0.
  - Else if a rename hits rs: busy = 1, q = `rn_tag_in`.
  - Else if a same-cycle commit clears rs: busy = 0.
  - Else: table entry.
- `rdy_in` = 0: all arrays hold. Read outputs still reflect the table plus the current-cycle inputs.

## Timing
- Reads have zero latency (combinational). Writes take effect at the clock edge; a read in the next cycle sees them from the table.
- Asynchronous reset: all val, busy and tag cleared immediately. Outputs then read v=0, q=0, busy=0.
- Reset asserted mid-rename or mid-commit: the in-flight update is lost. No partial write is permitted.
- No handshake: inputs are qualified by their enables and are assumed valid for the whole cycle.
- ROB tag wrap-around is the ROB's responsibility. Tag equality is the only comparison performed here.

## Structure
- Shared package: `XLEN`, `ROB_W`, `NREG` defaults, plus `REG_ZERO`, `DATA_ZERO`, `TAG_ZERO`.
- One sub-module, `rsf_read_port`: the bypass and priority mux for one port, generated `NRP` times.
- The top-level module holds the arrays, the commit merge and the rename/flush write logic.

## Test plan
- Reset → read x5 on both ports: v=0, busy=0, q=0. Rename x0 with tag 3 → x0 still reads busy=0.
- Rename x5 with tag 7. Same cycle: read x5 → busy=1, q=7. Next cycle: table holds busy=1, q=7.
- x5 busy with tag 7, commit (x5, 0xDEAD, tag 7) → same-cycle read v=0xDEAD, busy=0. Next cycle: table shows val 0xDEAD, busy=0.
- x5 busy with tag 9, commit (x5, 0x11, tag 7) → val=0x11, busy stays 1, q=9. Same-cycle rename x6 plus commit x6 matching → x6 busy with the new tag.
- NCP=2, both ports commit x8 with values 1 and 2 → same-cycle read v=2, and val[x8]=2 afterwards.
- Several registers busy, `flush_in` together with rename x3 (tag 4) and commit x3 (value 5) → all busy=0, val[x3]=5, x3 not busy. With `rdy_in`=0, rename x4 → no state change.
